dram_feature_rd_sched: RTL and testbench

DRAM_FEATURE_RD_SCHED -- requirements
Module: dram_feature_rd_sched

---
 rtl/dram_feature_rd_sched.sv | 162 ++++++++++++++++
 tb/tb_dram_feature_rd_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_feature_rd_sched.sv
// Row-by-row AXI read-address scheduler for a feature map: splits each row into
// bursts of at most 16 beats that never cross 4 KB, gated by row-buffer credits.
//   state       | meaning
//   IDLE        | waiting for a start edge
//   CALC        | beats_per_row settling; zero-size layers skip to DONE
//   WAIT_CREDIT | row buffer needed before issuing the row
//   ISSUE       | presenting bursts of the current row, one at a time
//   NEXT_ROW    | advance row address or finish
//   DONE        | one-cycle completion pulse
module dram_feature_rd_sched #(
  parameter int W_WIDTH     = 10,
  parameter int LITEWIDTH   = 32,
  parameter int DEPTHWIDTH  = 9,
  parameter int AXIWIDTH    = 128,
  parameter int ROW_CREDITS = 2
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic                  I_ap_start,
  input  logic [LITEWIDTH-1:0]  I_feature_base_addr,
  input  logic [DEPTHWIDTH-1:0] I_ciMemGroup,
  input  logic [W_WIDTH-1:0]    I_iwidth,
  input  logic [W_WIDTH-1:0]    I_iheight,
  input  logic                  I_row_credit,
  output logic                  O_arvalid,
  input  logic                  I_arready,
  output logic [LITEWIDTH-1:0]  O_araddr,
  output logic [7:0]            O_arlen,
  output logic                  O_row_start,
  output logic [W_WIDTH-1:0]    O_row_index,
  output logic                  O_busy,
  output logic                  O_done
);

  localparam int PW         = DEPTHWIDTH + W_WIDTH;
  localparam int CW         = $clog2(ROW_CREDITS + 1);
  localparam int BEAT_SHIFT = $clog2(AXIWIDTH / 8);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_CALC        = 3'd1;
  localparam logic [2:0] S_WAIT_CREDIT = 3'd2;
  localparam logic [2:0] S_ISSUE       = 3'd3;
  localparam logic [2:0] S_NEXT_ROW    = 3'd4;
  localparam logic [2:0] S_DONE        = 3'd5;

  logic [2:0]           state;
  logic                 start_q;
  logic                 start_acc;
  logic [W_WIDTH-1:0]   ih_q;
  logic [PW-1:0]        bpr;
  logic [PW-1:0]        rem;
  logic [PW-1:0]        rem_next;
  logic [LITEWIDTH-1:0] row_addr;
  logic [LITEWIDTH-1:0] row_bytes;
  logic [LITEWIDTH-1:0] burst_bytes;
  logic [CW-1:0]        credit_cnt;
  logic                 first_burst;
  logic                 hs;
  logic [12:0]          lim_4k;
  logic [4:0]           burst_len;

  assign start_acc   = I_ap_start & ~start_q & (state == S_IDLE);
  assign hs          = O_arvalid & I_arready;
  assign row_bytes   = LITEWIDTH'({bpr, {BEAT_SHIFT{1'b0}}});
  assign burst_bytes = LITEWIDTH'({1'b0, O_arlen} + 9'd1) << BEAT_SHIFT;
  assign rem_next    = rem - PW'({1'b0, O_arlen} + 9'd1);

  assign O_row_start = hs & first_burst;
  assign O_busy      = (state != S_IDLE);
  assign O_done      = (state == S_DONE);

  // Burst length: min(16, remaining beats, beats left before the 4 KB page end).
  always_comb begin
    lim_4k = (13'd4096 - {1'b0, O_araddr[11:0]}) >> BEAT_SHIFT;
    if (lim_4k == 13'd0) lim_4k = 13'd1;
    burst_len = 5'd16;
    if (rem < PW'(16)) burst_len = rem[4:0];
    if (lim_4k < 13'(burst_len)) burst_len = lim_4k[4:0];
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state       <= S_IDLE;
      start_q     <= 1'b0;
      ih_q        <= '0;
      bpr         <= '0;
      rem         <= '0;
      row_addr    <= '0;
      first_burst <= 1'b0;
      O_arvalid   <= 1'b0;
      O_araddr    <= '0;
      O_arlen     <= '0;
      O_row_index <= '0;
    end else begin
      start_q <= I_ap_start;
      case (state)
        S_IDLE: begin
          if (start_acc) begin
            row_addr    <= I_feature_base_addr;
            ih_q        <= I_iheight;
            bpr         <= PW'(I_ciMemGroup) * PW'(I_iwidth);
            O_row_index <= '0;
            state       <= S_CALC;
          end
        end
        S_CALC: begin
          if (ih_q == '0 || bpr == '0) state <= S_DONE;
          else                         state <= S_WAIT_CREDIT;
        end
        S_WAIT_CREDIT: begin
          if (credit_cnt != '0) begin
            O_araddr    <= row_addr;
            rem         <= bpr;
            first_burst <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (O_arvalid) begin
            if (I_arready) begin
              // Drop valid for a cycle so the next burst length sees the new address.
              O_arvalid   <= 1'b0;
              O_araddr    <= O_araddr + burst_bytes;
              rem         <= rem_next;
              first_burst <= 1'b0;
              if (rem_next == '0) state <= S_NEXT_ROW;
            end
          end else begin
            O_arvalid <= 1'b1;
            O_arlen   <= {3'b000, burst_len - 5'd1};
          end
        end
        S_NEXT_ROW: begin
          if (O_row_index == ih_q - W_WIDTH'(1)) begin
            state <= S_DONE;
          end else begin
            O_row_index <= O_row_index + W_WIDTH'(1);
            row_addr    <= row_addr + row_bytes;
            state       <= S_WAIT_CREDIT;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      credit_cnt <= '0;
    end else if (start_acc) begin
      credit_cnt <= CW'(ROW_CREDITS);
    end else if (O_row_start && I_row_credit) begin
      credit_cnt <= credit_cnt;
    end else if (O_row_start) begin
      credit_cnt <= credit_cnt - CW'(1);
    end else if (I_row_credit && credit_cnt < CW'(ROW_CREDITS)) begin
      credit_cnt <= credit_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_dram_feature_rd_sched.sv
// Scoreboard bench for dram_feature_rd_sched: expected bursts are queued from a
// reference model when a layer is started and popped at each AR handshake.
module tb_dram_feature_rd_sched;

  logic        I_clk = 1'b0;
  logic        I_rst_n;
  logic        I_ap_start;
  logic [31:0] I_feature_base_addr;
  logic [8:0]  I_ciMemGroup;
  logic [9:0]  I_iwidth;
  logic [9:0]  I_iheight;
  logic        I_row_credit;
  logic        O_arvalid;
  logic        I_arready;
  logic [31:0] O_araddr;
  logic [7:0]  O_arlen;
  logic        O_row_start;
  logic [9:0]  O_row_index;
  logic        O_busy;
  logic        O_done;

  always #5 I_clk = ~I_clk;

  dram_feature_rd_sched #(
    .W_WIDTH(10), .LITEWIDTH(32), .DEPTHWIDTH(9), .AXIWIDTH(128), .ROW_CREDITS(2)
  ) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_ap_start(I_ap_start),
    .I_feature_base_addr(I_feature_base_addr), .I_ciMemGroup(I_ciMemGroup),
    .I_iwidth(I_iwidth), .I_iheight(I_iheight), .I_row_credit(I_row_credit),
    .O_arvalid(O_arvalid), .I_arready(I_arready), .O_araddr(O_araddr),
    .O_arlen(O_arlen), .O_row_start(O_row_start), .O_row_index(O_row_index),
    .O_busy(O_busy), .O_done(O_done)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [9:0]  row;
    logic        rs;
  } burst_t;

  burst_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_push(input logic [31:0] base, input int ci, input int iw, input int ih);
    int bpr, rem, lim, len;
    logic [31:0] a;
    logic first;
    burst_t b;
    bpr = ci * iw;
    for (int r = 0; r < ih; r++) begin
      a = base + 32'(r * bpr * 16);
      rem = bpr;
      first = 1'b1;
      while (rem > 0) begin
        lim = (4096 - int'(a[11:0])) / 16;
        len = 16;
        if (rem < len) len = rem;
        if (lim < len) len = lim;
        b.addr = a; b.len = 8'(len - 1); b.row = 10'(r); b.rs = first;
        exp_q.push_back(b);
        a = a + 32'(len * 16);
        rem = rem - len;
        first = 1'b0;
      end
    end
  endtask

  task automatic start_layer(input logic [31:0] base, input int ci, input int iw, input int ih);
    @(posedge I_clk); #1;
    I_feature_base_addr = base;
    I_ciMemGroup = 9'(ci);
    I_iwidth = 10'(iw);
    I_iheight = 10'(ih);
    I_ap_start = 1'b1;
    @(posedge I_clk); #1;
    I_ap_start = 1'b0;
  endtask

  task automatic credit_pulse();
    @(posedge I_clk); #1;
    I_row_credit = 1'b1;
    @(posedge I_clk); #1;
    I_row_credit = 1'b0;
  endtask

  task automatic run_layer(input string name, input int max_cyc, input int stall_n,
                           input bit auto_credit, input bit expect_done,
                           output int n_rs, output int n_done);
    int cyc, stalls, last_hs, done_cyc, tail;
    bit hs, hs_prev, pend, credit_next;
    logic [31:0] p_addr;
    logic [7:0] p_len;
    burst_t e;
    cyc = 0; stalls = 0; last_hs = -100; done_cyc = -1; tail = 0;
    hs_prev = 0; pend = 0; n_rs = 0; n_done = 0;
    I_arready = (stall_n == 0);
    while (cyc < max_cyc) begin
      @(negedge I_clk);
      cyc++;
      if (pend) begin
        n_checks++;
        if (O_arvalid !== 1'b1 || O_araddr !== p_addr || O_arlen !== p_len) begin
          n_fail++;
          $display("FAIL %s ar_stable: got v=%b a=%h l=%0d want v=1 a=%h l=%0d",
                   name, O_arvalid, O_araddr, O_arlen, p_addr, p_len);
        end
      end
      if (hs_prev) begin
        n_checks++;
        if (O_arvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s ar_gap: got arvalid=%b want 0 after handshake", name, O_arvalid);
        end
      end
      hs = (O_arvalid === 1'b1) && (I_arready === 1'b1);
      pend = (O_arvalid === 1'b1) && (I_arready === 1'b0);
      p_addr = O_araddr;
      p_len = O_arlen;
      if (pend) stalls++;
      credit_next = 1'b0;
      if (hs) begin
        last_hs = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s burst: got unexpected burst a=%h l=%0d, want none", name, O_araddr, O_arlen);
        end else begin
          e = exp_q.pop_front();
          if (O_araddr !== e.addr || O_arlen !== e.len || O_row_index !== e.row || O_row_start !== e.rs) begin
            n_fail++;
            $display("FAIL %s burst: got a=%h l=%0d row=%0d rs=%b want a=%h l=%0d row=%0d rs=%b",
                     name, O_araddr, O_arlen, O_row_index, O_row_start, e.addr, e.len, e.row, e.rs);
          end
        end
      end
      if (O_row_start === 1'b1) begin
        n_rs++;
        credit_next = auto_credit;
      end
      if (O_done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      hs_prev = hs;
      if (done_cyc >= 0) tail++;
      if (tail > 3) break;
      @(posedge I_clk); #1;
      I_row_credit = credit_next;
      if (stall_n > 0 && stalls >= stall_n) I_arready = 1'b1;
    end
    I_row_credit = 1'b0;
    if (expect_done) begin
      n_checks++;
      if (done_cyc < 0) begin
        n_fail++;
        $display("FAIL %s done_timeout: got no O_done in %0d cycles, want one", name, max_cyc);
      end else if (done_cyc - last_hs !== 2) begin
        n_fail++;
        $display("FAIL %s done_latency: got %0d cycles after last AR, want 2", name, done_cyc - last_hs);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL %s missing_bursts: got %0d left in queue, want 0", name, exp_q.size());
      end
    end
    if (stall_n > 0) begin
      n_checks++;
      if (stalls != stall_n) begin
        n_fail++;
        $display("FAIL %s stall_cycles: got %0d, want %0d", name, stalls, stall_n);
      end
    end
  endtask

  task automatic test_reset();
    I_rst_n = 1'b0; I_ap_start = 1'b0; I_row_credit = 1'b0; I_arready = 1'b0;
    I_feature_base_addr = '0; I_ciMemGroup = '0; I_iwidth = '0; I_iheight = '0;
    #22;
    n_checks++;
    if ({O_arvalid, O_araddr, O_arlen, O_row_start, O_row_index, O_busy, O_done} !== 55'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b a=%h l=%0d rs=%b row=%0d busy=%b done=%b want all 0",
               O_arvalid, O_araddr, O_arlen, O_row_start, O_row_index, O_busy, O_done);
    end
    // Start held high through reset release counts as a fresh edge.
    I_iheight = 10'd0; I_ciMemGroup = 9'd1; I_iwidth = 10'd1;
    I_ap_start = 1'b1;
    @(negedge I_clk);
    I_rst_n = 1'b1;
    @(negedge I_clk);
    n_checks++;
    if (O_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_start_edge: got busy=%b want 1", O_busy);
    end
    repeat (3) @(posedge I_clk);
    #1 I_ap_start = 1'b0;
  endtask

  task automatic test_basic();
    int rs, dn;
    model_push(32'h1000, 2, 12, 3);
    start_layer(32'h1000, 2, 12, 3);
    run_layer("basic", 400, 0, 1, 1, rs, dn);
    n_checks++;
    if (rs != 3 || dn != 1) begin
      n_fail++;
      $display("FAIL basic_counts: got row_starts=%0d dones=%0d want 3 and 1", rs, dn);
    end
  endtask

  task automatic test_split_4k();
    int rs, dn;
    model_push(32'h0FC0, 1, 8, 1);
    start_layer(32'h0FC0, 1, 8, 1);
    run_layer("split_4k", 200, 0, 1, 1, rs, dn);
    n_checks++;
    if (rs != 1 || dn != 1) begin
      n_fail++;
      $display("FAIL split_4k_counts: got row_starts=%0d dones=%0d want 1 and 1", rs, dn);
    end
  endtask

  task automatic test_ar_stall();
    int rs, dn;
    model_push(32'h2000, 1, 4, 2);
    start_layer(32'h2000, 1, 4, 2);
    run_layer("ar_stall", 200, 5, 1, 1, rs, dn);
    n_checks++;
    if (rs != 2 || dn != 1) begin
      n_fail++;
      $display("FAIL ar_stall_counts: got row_starts=%0d dones=%0d want 2 and 1", rs, dn);
    end
  endtask

  task automatic test_credit();
    int rs, dn;
    model_push(32'h3000, 1, 4, 4);
    start_layer(32'h3000, 1, 4, 4);
    run_layer("credit_a", 60, 0, 0, 0, rs, dn);
    @(negedge I_clk);
    n_checks++;
    if (rs != 2 || dn != 0 || O_busy !== 1'b1 || O_arvalid !== 1'b0 || exp_q.size() != 2) begin
      n_fail++;
      $display("FAIL credit_stall: got rs=%0d done=%0d busy=%b v=%b left=%0d want 2 0 1 0 2",
               rs, dn, O_busy, O_arvalid, exp_q.size());
    end
    credit_pulse();
    run_layer("credit_b", 30, 0, 0, 0, rs, dn);
    n_checks++;
    if (rs != 1 || dn != 0) begin
      n_fail++;
      $display("FAIL credit_one_row: got row_starts=%0d dones=%0d want 1 and 0", rs, dn);
    end
    credit_pulse();
    run_layer("credit_c", 60, 0, 0, 1, rs, dn);
    n_checks++;
    if (rs != 1 || dn != 1) begin
      n_fail++;
      $display("FAIL credit_finish: got row_starts=%0d dones=%0d want 1 and 1", rs, dn);
    end
  endtask

  task automatic test_zero_size();
    int rs, dn;
    bit ok;
    @(posedge I_clk); #1;
    I_iheight = 10'd0; I_ciMemGroup = 9'd2; I_iwidth = 10'd3;
    I_ap_start = 1'b1;
    @(negedge I_clk);
    @(posedge I_clk); #1 I_ap_start = 1'b0;
    @(negedge I_clk);
    n_checks++;
    if (O_busy !== 1'b1 || O_done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_calc: got busy=%b done=%b want 1 0", O_busy, O_done);
    end
    @(posedge I_clk); #1 I_ap_start = 1'b1;
    @(negedge I_clk);
    n_checks++;
    if (O_done !== 1'b1 || O_arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: got done=%b arvalid=%b want 1 0", O_done, O_arvalid);
    end
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge I_clk); #1;
      if (i == 3) I_ap_start = 1'b0;
      @(negedge I_clk);
      if (O_done !== 1'b0 || O_arvalid !== 1'b0 || O_busy !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL zero_no_restart: got extra activity (done/arvalid/busy), want idle");
    end
    start_layer(32'h4000, 0, 5, 2);
    run_layer("zero_bpr", 20, 0, 1, 0, rs, dn);
    n_checks++;
    if (rs != 0 || dn != 1) begin
      n_fail++;
      $display("FAIL zero_bpr: got row_starts=%0d dones=%0d want 0 and 1", rs, dn);
    end
  endtask

  task automatic test_reset_mid();
    int rs, dn, t;
    I_arready = 1'b0;
    start_layer(32'h1000, 2, 12, 3);
    t = 0;
    while (O_arvalid !== 1'b1 && t < 20) begin
      @(negedge I_clk);
      t++;
    end
    n_checks++;
    if (O_arvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_arvalid: got arvalid=%b want 1 within 20 cycles", O_arvalid);
    end
    @(negedge I_clk);
    I_rst_n = 1'b0;
    #1;
    n_checks++;
    if (O_arvalid !== 1'b0 || O_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got arvalid=%b busy=%b want 0 0", O_arvalid, O_busy);
    end
    #2 I_rst_n = 1'b1;
    model_push(32'h1000, 2, 12, 3);
    start_layer(32'h1000, 2, 12, 3);
    run_layer("reset_restart", 400, 0, 1, 1, rs, dn);
    n_checks++;
    if (rs != 3 || dn != 1) begin
      n_fail++;
      $display("FAIL reset_restart_counts: got row_starts=%0d dones=%0d want 3 and 1", rs, dn);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split_4k();
    test_ar_stall();
    test_credit();
    test_zero_size();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
